// File: rtl/fourbit_counter_pkg.sv
// Shared constants and FSM state encoding for the down counter.
// Latency: n/a. Backpressure: n/a.
package fourbit_counter_pkg;

  localparam int WIDTH_DEFAULT = 4;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage : fourbit_counter_pkg

// File: rtl/down_count_stage.sv
// WIDTH-bit count register with synchronous load (priority) and decrement.
// Latency: 1 cycle from load/dec to count_o. Backpressure: none.
module down_count_stage #(
  parameter int WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             dec_i,
  output logic [WIDTH-1:0] count_o
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i) begin
      count_d = count_q - ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule : down_count_stage

// File: rtl/fourbit_down_counter.sv
// Down counter with reload register, one-shot/periodic modes and borrow/done pulses.
// Latency: 1 cycle for all state and pulses. Backpressure: none (en gates counting).
module fourbit_down_counter
  import fourbit_counter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             stop,
  input  logic             periodic,
  output logic [WIDTH-1:0] count,
  output logic             zero,
  output logic             borrow,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             borrow_q, borrow_d;
  logic             done_q, done_d;

  logic             cnt_ld;
  logic [WIDTH-1:0] cnt_ld_val;
  logic             cnt_dec;

  always_comb begin
    state_d    = state_q;
    reload_d   = reload_q;
    borrow_d   = 1'b0;
    done_d     = 1'b0;
    cnt_ld     = 1'b0;
    cnt_ld_val = load_val;
    cnt_dec    = 1'b0;

    if (load) begin
      reload_d   = load_val;
      cnt_ld     = 1'b1;
      cnt_ld_val = load_val;
    end else begin
      case (state_q)
        IDLE: begin
          // stop outranks start even when already idle
          if (!stop && start) begin
            cnt_ld     = 1'b1;
            cnt_ld_val = reload_q;
            state_d    = RUN;
          end
        end
        RUN: begin
          if (stop) begin
            state_d = IDLE;
          end else if (en) begin
            if (count != '0) begin
              cnt_dec = 1'b1;
            end else if (periodic) begin
              cnt_ld     = 1'b1;
              cnt_ld_val = reload_q;
              borrow_d   = 1'b1;
            end else begin
              borrow_d = 1'b1;
              done_d   = 1'b1;
              state_d  = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      reload_q <= '0;
      borrow_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      reload_q <= reload_d;
      borrow_q <= borrow_d;
      done_q   <= done_d;
    end
  end

  down_count_stage #(
    .WIDTH (WIDTH)
  ) u_count (
    .clk_i      (clk),
    .reset_n_i  (reset_n),
    .load_i     (cnt_ld),
    .load_val_i (cnt_ld_val),
    .dec_i      (cnt_dec),
    .count_o    (count)
  );

  assign zero   = (count == '0);
  assign borrow = borrow_q;
  assign done   = done_q;
  assign busy   = (state_q == RUN);

endmodule : fourbit_down_counter

// File: tb/tb_fourbit_down_counter.sv
// Bench for fourbit_down_counter: directed scenarios plus randomized run against a cycle model.
module tb_fourbit_down_counter;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset_n, en, load, start, stop, periodic;
  logic [W-1:0] load_val;
  logic [W-1:0] count;
  logic         zero, borrow, busy, done;

  int tests = 0;
  int fails = 0;

  logic [W-1:0] m_count, m_reload;
  bit           m_run, m_borrow, m_done;

  fourbit_down_counter #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .en       (en),
    .load     (load),
    .load_val (load_val),
    .start    (start),
    .stop     (stop),
    .periodic (periodic),
    .count    (count),
    .zero     (zero),
    .borrow   (borrow),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Cycle model written straight from the behavioural rules.
  task automatic model_step();
    bit nb, nd;
    nb = 0;
    nd = 0;
    if (!reset_n) begin
      m_count = '0; m_reload = '0; m_run = 0;
    end else if (load) begin
      m_reload = load_val;
      m_count  = load_val;
    end else if (m_run) begin
      if (stop) m_run = 0;
      else if (en) begin
        if (m_count > 0) m_count = m_count - 4'd1;
        else begin
          nb = 1;
          if (periodic) m_count = m_reload;
          else begin nd = 1; m_run = 0; end
        end
      end
    end else if (!stop && start) begin
      m_count = m_reload;
      m_run   = 1;
    end
    m_borrow = nb;
    m_done   = nd;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic quiet();
    en = 0; load = 0; start = 0; stop = 0; periodic = 0; load_val = '0;
  endtask

  task automatic test_reset();
    reset_n = 1;
    for (int i = 0; i < 6; i++) begin
      en = 1'($urandom); load = 1'($urandom); start = 1'($urandom);
      periodic = 1'($urandom); load_val = 4'($urandom);
      tick();
    end
    quiet();
    reset_n = 0;
    tick(); tick();
    tests++; if (count !== 4'd0) begin fails++; $display("FAIL reset_count got %0d want 0", count); end
    tests++; if (zero !== 1'b1) begin fails++; $display("FAIL reset_zero got %b want 1", zero); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    tests++; if (borrow !== 1'b0) begin fails++; $display("FAIL reset_borrow got %b want 0", borrow); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", done); end
    reset_n = 1;
  endtask

  task automatic test_oneshot();
    int exp_seq[3] = '{2, 1, 0};
    quiet();
    load_val = 4'd3; load = 1; tick();
    load = 0; start = 1; tick();
    start = 0;
    tests++; if (count !== 4'd3 || busy !== 1'b1) begin
      fails++; $display("FAIL oneshot_start count=%0d busy=%b want 3/1", count, busy);
    end
    en = 1;
    foreach (exp_seq[i]) begin
      tick();
      tests++; if (count !== 4'(exp_seq[i]) || done !== 1'b0) begin
        fails++; $display("FAIL oneshot_count[%0d] count=%0d done=%b want %0d/0", i, count, done, exp_seq[i]);
      end
    end
    tick();
    tests++; if (done !== 1'b1 || borrow !== 1'b1 || busy !== 1'b0 || count !== 4'd0) begin
      fails++; $display("FAIL oneshot_term done=%b borrow=%b busy=%b count=%0d want 1/1/0/0", done, borrow, busy, count);
    end
    tick();
    tests++; if (done !== 1'b0 || borrow !== 1'b0) begin
      fails++; $display("FAIL oneshot_pulse_width done=%b borrow=%b want 0/0", done, borrow);
    end
    quiet();
  endtask

  task automatic test_periodic();
    int exp_seq[9] = '{2, 1, 0, 2, 1, 0, 2, 1, 0};
    int prev;
    quiet();
    load_val = 4'd2; load = 1; tick();
    load = 0; periodic = 1; en = 1; start = 1;
    prev = -1;
    foreach (exp_seq[i]) begin
      tick();
      start = 0;
      tests++; if (count !== 4'(exp_seq[i]) || borrow !== (prev == 0) || busy !== 1'b1) begin
        fails++; $display("FAIL periodic[%0d] count=%0d borrow=%b busy=%b want %0d/%b/1",
                          i, count, borrow, busy, exp_seq[i], prev == 0);
      end
      prev = exp_seq[i];
    end
    tick();
    tests++; if (borrow !== 1'b1 || count !== 4'd2 || done !== 1'b0) begin
      fails++; $display("FAIL periodic_wrap borrow=%b count=%0d done=%b want 1/2/0", borrow, count, done);
    end
    en = 0; stop = 1; tick();
    quiet();
  endtask

  task automatic test_en_gating_stop();
    int exp_cnt;
    int cyc;
    quiet();
    load_val = 4'd15; load = 1; tick();
    load = 0; start = 1; tick();
    start = 0;
    exp_cnt = 15;
    cyc = 0;
    while (exp_cnt != 9 && cyc < 40) begin
      en = (cyc % 2 == 0);
      tick();
      if (en) exp_cnt--;
      tests++; if (count !== 4'(exp_cnt)) begin
        fails++; $display("FAIL en_gate[%0d] count=%0d want %0d", cyc, count, exp_cnt);
      end
      cyc++;
    end
    en = 1; stop = 1; tick();
    stop = 0;
    tests++; if (busy !== 1'b0 || count !== 4'd9) begin
      fails++; $display("FAIL stop busy=%b count=%0d want 0/9", busy, count);
    end
    tick();
    tests++; if (count !== 4'd9 || borrow !== 1'b0 || done !== 1'b0) begin
      fails++; $display("FAIL stop_hold count=%0d borrow=%b done=%b want 9/0/0", count, borrow, done);
    end
    quiet();
  endtask

  task automatic test_load_at_zero();
    quiet();
    load_val = 4'd1; load = 1; tick();
    load = 0; start = 1; tick();
    start = 0; en = 1; tick();
    tests++; if (count !== 4'd0 || busy !== 1'b1) begin
      fails++; $display("FAIL lz_setup count=%0d busy=%b want 0/1", count, busy);
    end
    load = 1; load_val = 4'd5; tick();
    load = 0; en = 0;
    tests++; if (count !== 4'd5 || borrow !== 1'b0 || done !== 1'b0 || busy !== 1'b1) begin
      fails++; $display("FAIL load_at_zero count=%0d borrow=%b done=%b busy=%b want 5/0/0/1",
                        count, borrow, done, busy);
    end
    stop = 1; tick();
    quiet();
  endtask

  task automatic test_reset_mid();
    quiet();
    load_val = 4'd4; load = 1; tick();
    load = 0; start = 1; tick();
    start = 0; en = 1;
    tick(); tick(); tick();
    tests++; if (count !== 4'd1 || busy !== 1'b1) begin
      fails++; $display("FAIL rm_setup count=%0d busy=%b want 1/1", count, busy);
    end
    reset_n = 0; tick();
    tests++; if (count !== 4'd0 || busy !== 1'b0) begin
      fails++; $display("FAIL reset_mid count=%0d busy=%b want 0/0", count, busy);
    end
    reset_n = 1; en = 0; tick();
    tests++; if (done !== 1'b0 || borrow !== 1'b0) begin
      fails++; $display("FAIL reset_mid_pulse done=%b borrow=%b want 0/0", done, borrow);
    end
    quiet();
  endtask

  task automatic test_random();
    bit prev_b, prev_d;
    prev_b = 0;
    prev_d = 0;
    for (int i = 0; i < 400; i++) begin
      reset_n  = ($urandom_range(0, 49) != 0);
      load     = ($urandom_range(0, 11) == 0);
      stop     = ($urandom_range(0, 15) == 0);
      start    = ($urandom_range(0, 3) == 0);
      en       = ($urandom_range(0, 3) != 0);
      periodic = 1'($urandom);
      load_val = 4'($urandom_range(0, 6));
      tick();
      tests++;
      if (count !== m_count || zero !== (m_count == 0) || busy !== m_run ||
          borrow !== m_borrow || done !== m_done || (prev_b && borrow && !m_borrow) ||
          (prev_d && done)) begin
        fails++;
        $display("FAIL random[%0d] count=%0d zero=%b busy=%b borrow=%b done=%b want %0d/%b/%b/%b/%b",
                 i, count, zero, busy, borrow, done, m_count, m_count == 0, m_run, m_borrow, m_done);
      end
      prev_b = borrow;
      prev_d = done;
    end
    quiet();
    reset_n = 1;
  endtask

  initial begin
    quiet();
    reset_n = 0;
    tick(); tick();
    test_reset();
    test_oneshot();
    test_periodic();
    test_en_gating_stop();
    test_load_at_zero();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_fourbit_down_counter

// File: doc/fourbit_down_counter.md
FOURBIT_DOWN_COUNTER -- requirements
Module: fourbit_down_counter

Interface
REQ-001 Parameter WIDTH, default 4, counter and reload register width in bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  reset, synchronous, active-low.
REQ-004 en  input  1  count enable; decrement permitted only when 1.
REQ-005 load  input  1  capture load_val into reload register and count.
REQ-006 load_val  input  WIDTH  reload value.
REQ-007 start  input  1  begin a countdown from reload value.
REQ-008 stop  input  1  abort countdown, return to IDLE.
REQ-009 periodic  input  1  1 = auto-reload at terminal count; 0 = one-shot.
REQ-010 count  output  WIDTH  current counter value, registered.
REQ-011 zero  output  1  count == 0, combinational decode of count register.
REQ-012 borrow  output  1  one-cycle registered pulse on wrap from 0.
REQ-013 busy  output  1  1 while in RUN state.
REQ-014 done  output  1  one-cycle registered pulse on one-shot completion.

Function
REQ-015 FSM states: IDLE, RUN; state encoding from shared package.
REQ-016 Per-edge priority: reset_n=0 > load > stop > start > decrement.
REQ-017 load=1 (any state): reload_q <= load_val, count <= load_val; state unchanged; no decrement that cycle.
REQ-018 IDLE, start=1: count <= reload_q, next state RUN; count holds otherwise.
REQ-019 RUN, stop=1: next state IDLE, count holds, no borrow/done.
REQ-020 RUN, en=0: count and state hold.
REQ-021 RUN, en=1, count != 0: count <= count - 1, modulo 2^WIDTH arithmetic.
REQ-022 RUN, en=1, count == 0, periodic=1: count <= reload_q, stay RUN, borrow=1 next cycle.
REQ-023 RUN, en=1, count == 0, periodic=0: count stays 0, next state IDLE, borrow=1 and done=1 next cycle.
REQ-024 reload_q == 0 with periodic=1: borrow asserts every enabled cycle in RUN.
REQ-025 start while in RUN: ignored.
REQ-026 borrow and done are never asserted longer than one cycle per event.
REQ-027 periodic sampled at the terminal-count cycle only; changes mid-count take effect at next wrap.

Reset
REQ-028 reset_n=0 at a rising edge: state <= IDLE, count <= 0, reload_q <= 0, borrow <= 0, done <= 0, busy <= 0.
REQ-029 Reset mid-countdown overrides load, start and pending terminal count in the same cycle; no borrow/done pulse follows.
REQ-030 reset_n ignored between clock edges; no asynchronous path to any register.

Structure
REQ-031 Package fourbit_counter_pkg holds WIDTH default constant and the state enum (IDLE, RUN).
REQ-032 One sub-module, down_count_stage: WIDTH-bit register with synchronous active-low reset, load and decrement, instantiated once for count.
REQ-033 reload_q, FSM and pulse registers live in the top module.

Verification
REQ-034 reset_n=0 for 2 cycles after arbitrary activity -> count=0, zero=1, busy=0, borrow=0, done=0.
REQ-035 load_val=3, load; periodic=0, start, en=1 -> count 3,2,1,0; next edge done=1, borrow=1 for one cycle, busy=0.
REQ-036 load_val=2, periodic=1, start, en=1 for 9 cycles -> count 2,1,0,2,1,0,2,1,0; borrow pulses after each 0.
REQ-037 load_val=15, start, en toggled 1/0 -> count decrements only on en=1 cycles; stop at count=9 -> IDLE, count holds 9.
REQ-038 RUN at count=0 with en=1, load=1, load_val=5 same cycle -> count=5, no borrow, no done, stays RUN.
REQ-039 RUN at count=1, reset_n=0 same cycle as en=1 -> count=0, IDLE, no done pulse next cycle.
